// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared constants and colour packing helpers for the gfx layer compositor
package gfx_pkg;

  localparam int NUM_LAYERS_DEF = 6;
  localparam int COLOR_W_DEF    = 8;
  localparam int COORD_W_DEF    = 16;
  localparam int ID_W_DEF       = 3;

  // Input-to-output latency of the compositor in pixel clocks
  localparam int LATENCY = 3;

  // Bit offsets of the channels inside a packed {R,G,B} word
  function automatic int r_lsb(input int color_w);
    return 2 * color_w;
  endfunction

  function automatic int g_lsb(input int color_w);
    return color_w;
  endfunction

  function automatic int b_lsb(input int color_w);
    return 0;
  endfunction

  // The background reports itself as the layer index one past the last sprite
  function automatic int bg_id(input int num_layers);
    return num_layers;
  endfunction

endpackage

// File: rtl/gfx_prio2_sel.sv
// rtl/gfx_prio2_sel.sv - finds the two lowest set indices of a layer mask
module gfx_prio2_sel #(
  parameter int NUM_LAYERS = 6,
  parameter int IDX_W      = 3
) (
  input  logic [NUM_LAYERS-1:0] eff,
  output logic                  top_valid,
  output logic [IDX_W-1:0]      top_idx,
  output logic                  sec_valid,
  output logic [IDX_W-1:0]      sec_idx
);

  // Scan from index 0 upward; first hit is the top layer, second hit the one beneath
  always_comb begin
    top_valid = 1'b0;
    top_idx   = '0;
    sec_valid = 1'b0;
    sec_idx   = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (eff[k]) begin
        if (!top_valid) begin
          top_valid = 1'b1;
          top_idx   = IDX_W'(k);
        end else if (!sec_valid) begin
          sec_valid = 1'b1;
          sec_idx   = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/gfx_layer_compositor.sv
// rtl/gfx_layer_compositor.sv - 3-stage sprite layer compositor with blend and per-frame collision flags
module gfx_layer_compositor
  import gfx_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int ID_W       = ID_W_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [COORD_W-1:0]              i_x,
  input  logic [COORD_W-1:0]              i_y,
  input  logic                            i_de,
  input  logic                            i_v_sync,
  input  logic [NUM_LAYERS-1:0]           i_hit,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0] i_rgb,
  input  logic [3*COLOR_W-1:0]            i_bg_rgb,
  input  logic [NUM_LAYERS-1:0]           i_layer_en,
  input  logic [NUM_LAYERS-1:0]           i_blend_en,
  output logic [COLOR_W-1:0]              o_red,
  output logic [COLOR_W-1:0]              o_green,
  output logic [COLOR_W-1:0]              o_blue,
  output logic [COORD_W-1:0]              o_x,
  output logic [COORD_W-1:0]              o_y,
  output logic                            o_de,
  output logic [ID_W-1:0]                 o_top_id,
  output logic [NUM_LAYERS-1:0]           o_collision
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int R_LSB = r_lsb(COLOR_W);
  localparam int G_LSB = g_lsb(COLOR_W);
  localparam int B_LSB = b_lsb(COLOR_W);
  localparam logic [ID_W-1:0] BG_ID = ID_W'(bg_id(NUM_LAYERS));

  // Floor average computed one bit wider so the carry is not lost
  function automatic logic [COLOR_W-1:0] avg(input logic [COLOR_W-1:0] a, input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COLOR_W:1];
  endfunction

  // Stage 1 state
  logic [COORD_W-1:0]            s1_x, s1_y;
  logic                          s1_de, s1_vs;
  logic [NUM_LAYERS-1:0]         s1_hit, s1_en, s1_blend;
  logic [NUM_LAYERS*PIX_W-1:0]   s1_rgb;
  logic [PIX_W-1:0]              s1_bg;

  // Stage 1: register every input unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_de    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_hit   <= '0;
      s1_en    <= '0;
      s1_blend <= '0;
      s1_rgb   <= '0;
      s1_bg    <= '0;
    end else begin
      s1_x     <= i_x;
      s1_y     <= i_y;
      s1_de    <= i_de;
      s1_vs    <= i_v_sync;
      s1_hit   <= i_hit;
      s1_en    <= i_layer_en;
      s1_blend <= i_blend_en;
      s1_rgb   <= i_rgb;
      s1_bg    <= i_bg_rgb;
    end
  end

  logic [NUM_LAYERS-1:0] eff;
  logic                  top_valid, sec_valid;
  logic [ID_W-1:0]       top_idx, sec_idx;

  assign eff = s1_hit & s1_en;

  gfx_prio2_sel #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (ID_W)
  ) u_sel (
    .eff       (eff),
    .top_valid (top_valid),
    .top_idx   (top_idx),
    .sec_valid (sec_valid),
    .sec_idx   (sec_idx)
  );

  logic [PIX_W-1:0] lay_rgb [NUM_LAYERS];

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_unpack
    assign lay_rgb[k] = s1_rgb[k*PIX_W +: PIX_W];
  end

  logic [PIX_W-1:0] sel_top_rgb, sel_sec_rgb;
  logic [ID_W-1:0]  sel_id;
  logic             sel_blend;

  // Background fills in for whichever of top/sec has no real layer behind it
  always_comb begin
    sel_top_rgb = s1_bg;
    sel_sec_rgb = s1_bg;
    sel_id      = BG_ID;
    sel_blend   = 1'b0;
    if (top_valid) begin
      sel_top_rgb = lay_rgb[top_idx];
      sel_id      = top_idx;
      sel_blend   = s1_blend[top_idx];
    end
    if (sec_valid) begin
      sel_sec_rgb = lay_rgb[sec_idx];
    end
  end

  logic [PIX_W-1:0]   s2_top_rgb, s2_sec_rgb;
  logic [ID_W-1:0]    s2_id;
  logic               s2_blend, s2_de;
  logic [COORD_W-1:0] s2_x, s2_y;

  // Stage 2: register the selection result with its pixel coordinates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_top_rgb <= '0;
      s2_sec_rgb <= '0;
      s2_id      <= '0;
      s2_blend   <= 1'b0;
      s2_de      <= 1'b0;
      s2_x       <= '0;
      s2_y       <= '0;
    end else begin
      s2_top_rgb <= sel_top_rgb;
      s2_sec_rgb <= sel_sec_rgb;
      s2_id      <= sel_id;
      s2_blend   <= sel_blend;
      s2_de      <= s1_de;
      s2_x       <= s1_x;
      s2_y       <= s1_y;
    end
  end

  // Stage 3: optional 50/50 blend with the layer beneath, then register the outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_red    <= '0;
      o_green  <= '0;
      o_blue   <= '0;
      o_top_id <= '0;
      o_de     <= 1'b0;
      o_x      <= '0;
      o_y      <= '0;
    end else begin
      if (s2_blend) begin
        o_red   <= avg(s2_top_rgb[R_LSB +: COLOR_W], s2_sec_rgb[R_LSB +: COLOR_W]);
        o_green <= avg(s2_top_rgb[G_LSB +: COLOR_W], s2_sec_rgb[G_LSB +: COLOR_W]);
        o_blue  <= avg(s2_top_rgb[B_LSB +: COLOR_W], s2_sec_rgb[B_LSB +: COLOR_W]);
      end else begin
        o_red   <= s2_top_rgb[R_LSB +: COLOR_W];
        o_green <= s2_top_rgb[G_LSB +: COLOR_W];
        o_blue  <= s2_top_rgb[B_LSB +: COLOR_W];
      end
      o_top_id <= s2_id;
      o_de     <= s2_de;
      o_x      <= s2_x;
      o_y      <= s2_y;
    end
  end

  logic                  vs_prev, vs_rise;
  logic [NUM_LAYERS-1:0] acc, contrib;

  // Two or more enabled layers hit on a visible pixel is exactly when a second layer exists
  assign contrib = (s1_de && sec_valid) ? eff : '0;
  assign vs_rise = s1_vs & ~vs_prev;

  // Accumulate overlaps over the frame and hand them to game logic at each frame start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_prev     <= 1'b0;
      acc         <= '0;
      o_collision <= '0;
    end else begin
      vs_prev <= s1_vs;
      if (vs_rise) begin
        o_collision <= acc | contrib;
        acc         <= '0;
      end else begin
        acc <= acc | contrib;
      end
    end
  end

endmodule
